conv_decoder_scheduler: RTL
===========================

CONV_DECODER_SCHEDULER -- requirements
Module: conv_decoder_scheduler

Interface
REQ-001 Parameter OUT_PIXELS, default 11520: output pixels per pass (180x64).
REQ-002 Parameter MAX_PASSES, default 8: largest accepted pass count.
REQ-003 Parameter CLEAR_CYCLES, default 2: cycles dec_rst is held before each pass.
REQ-004 Parameter WDOG_CYCLES, default 4096: maximum RUN-state gap between dec_ready pulses.
REQ-005 Reset/clock decision: one clock; reset is asynchronous and active-low (ports clk and rst).
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 cmd_valid  in  1  layer request.
REQ-009 cmd_passes  in  4  passes requested (output-channel groups).
REQ-010 cmd_ready  out  1  high only in IDLE.
REQ-011 abort  in  1  cancel the running layer.
REQ-012 dec_rst  out  1  synchronous active-high reset to the decoder datapath.
REQ-013 dec_start  out  1  run enable to the decoder datapath.
REQ-014 dec_ready  in  1  one-cycle valid per output pixel from the datapath.
REQ-015 wr_en  out  1  write strobe to the output buffer.
REQ-016 wr_addr  out  17  output buffer address (pass*OUT_PIXELS + pixel index).
REQ-017 pass_idx  out  3  current pass, also selects the weight bank.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 layer_done  out  1  one-cycle pulse on layer completion.
REQ-020 error  out  1  sticky watchdog or bad-command flag; cleared by the next accepted command.

Function
REQ-021 The FSM states SHALL be IDLE, CLEAR, RUN, NEXT and DONE.
REQ-022 IDLE: on cmd_valid with 1<=cmd_passes<=MAX_PASSES, latch cmd_passes, set pass_idx=0, clear error, go to CLEAR.
REQ-023 IDLE: on cmd_valid with cmd_passes==0 or >MAX_PASSES, set error=1 and remain in IDLE.
REQ-024 CLEAR: dec_rst=1 and dec_start=0 for exactly CLEAR_CYCLES cycles, pixel counter=0, then go to RUN.
REQ-025 RUN: dec_start=1 and dec_rst=0.
REQ-026 RUN: wr_en SHALL equal dec_ready combinationally, with wr_addr=pass_idx*OUT_PIXELS+pixel_cnt in the same cycle.
REQ-027 RUN: pixel_cnt increments on each dec_ready.
REQ-028 RUN: on the dec_ready that makes pixel_cnt reach OUT_PIXELS, dec_start drops next cycle and the FSM goes to NEXT.
REQ-029 NEXT: lasts one cycle; if pass_idx==passes-1 go to DONE, else increment pass_idx and go to CLEAR.
REQ-030 DONE: layer_done=1 for one cycle, then IDLE.
REQ-031 Watchdog: a counter resets on entry to RUN and on each dec_ready.
REQ-032 Watchdog: reaching WDOG_CYCLES sets error=1, asserts dec_rst for one cycle and returns to IDLE without layer_done.
REQ-033 abort in CLEAR, RUN or NEXT: next state IDLE, dec_start=0, dec_rst=1 for one cycle, no layer_done, error unchanged.
REQ-034 If abort coincides with the final dec_ready, abort wins; the write in that cycle still occurs.
REQ-035 dec_ready outside RUN SHALL be ignored: no wr_en, no count.
REQ-036 cmd_valid while busy SHALL be ignored; there is no queueing.
REQ-037 wr_addr arithmetic SHALL be unsigned 17-bit; the maximum is 8*11520-1=92159 with no wrap.

Reset
REQ-038 rst low SHALL asynchronously force IDLE, pass_idx=0, pixel_cnt=0, watchdog=0, error=0.
REQ-039 During rst low: dec_start=0, wr_en=0, wr_addr=0, layer_done=0, busy=0, cmd_ready=0.
REQ-040 During rst low, dec_rst=1 so the datapath is held in reset.
REQ-041 Reset deassertion mid-layer SHALL leave the block idle; no resume.

Structure
REQ-042 Package conv_decoder_pkg SHALL hold: the state enum; OUT_PIXELS, frame geometry (180x64, padded 186x70); address widths 14/17.
REQ-043 A single sub-module conv_decoder_watchdog (counter with clear/enable/expire) is natural; everything else is flat.

Verification
REQ-044 cmd_passes=1, dec_ready every cycle: 11520 writes at addr 0..11519, then layer_done at the NEXT+1 cycle; dec_rst high 2 cycles before RUN.
REQ-045 cmd_passes=3, dec_ready every other cycle: addresses 0..34559 contiguous, pass_idx 0,1,2, dec_rst pulses 3 times, one layer_done.
REQ-046 cmd_passes=0 and cmd_passes=9: error=1, busy stays 0, no dec_start; a following valid command clears error.
REQ-047 dec_ready stopped after pixel 100 of pass 0: after 4096 idle cycles error=1, IDLE, no layer_done.
REQ-048 abort on the final dec_ready of pass 1 of 2: the write at addr 23039 occurs, then IDLE, no layer_done, no pass 2 start.
REQ-049 rst asserted mid-RUN, asynchronously away from the clock edge: outputs reach reset values immediately; after release cmd_ready=1.

Source files
------------

// File: rtl/conv_decoder_pkg.sv
// rtl/conv_decoder_pkg.sv - shared geometry, address widths and state encoding for the conv decoder scheduler
package conv_decoder_pkg;

  localparam int FRAME_W        = 180;
  localparam int FRAME_H        = 64;
  localparam int PAD_W          = 186;
  localparam int PAD_H          = 70;
  localparam int OUT_PIXELS_DEF = FRAME_W * FRAME_H;

  localparam int PIX_AW = 14;
  localparam int BUF_AW = 17;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_NEXT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_CLEAR = ST_CLEAR,
    S_RUN   = ST_RUN,
    S_NEXT  = ST_NEXT,
    S_DONE  = ST_DONE
  } state_e;

endpackage

// File: rtl/conv_decoder_watchdog.sv
// rtl/conv_decoder_watchdog.sv - inactivity counter that expires after WDOG_CYCLES enabled cycles without a clear
module conv_decoder_watchdog #(
  parameter int WDOG_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(WDOG_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(WDOG_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry fires on the WDOG_CYCLES-th consecutive enabled cycle with no clear.
  assign expire_o = en_i && !clr_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/conv_decoder_scheduler.sv
// rtl/conv_decoder_scheduler.sv - sequences decoder passes, output buffer writes, watchdog and abort for one layer
module conv_decoder_scheduler
  import conv_decoder_pkg::*;
#(
  parameter int OUT_PIXELS   = OUT_PIXELS_DEF,
  parameter int MAX_PASSES   = 8,
  parameter int CLEAR_CYCLES = 2,
  parameter int WDOG_CYCLES  = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [3:0]        cmd_passes,
  output logic              cmd_ready,
  input  logic              abort,
  output logic              dec_rst,
  output logic              dec_start,
  input  logic              dec_ready,
  output logic              wr_en,
  output logic [BUF_AW-1:0] wr_addr,
  output logic [2:0]        pass_idx,
  output logic              busy,
  output logic              layer_done,
  output logic              error
);

  localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);
  localparam logic [CLR_W-1:0]  CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [PIX_AW-1:0] PIX_LAST = PIX_AW'(OUT_PIXELS - 1);
  localparam logic [BUF_AW-1:0] PASS_STRIDE = BUF_AW'(OUT_PIXELS);
  localparam logic [3:0]        MAX_P = 4'(MAX_PASSES);

  state_e            state_q, state_d;
  logic [3:0]        passes_q, passes_d;
  logic [2:0]        pass_q, pass_d;
  logic [PIX_AW-1:0] pix_q, pix_d;
  logic [CLR_W-1:0]  clr_q, clr_d;
  logic              error_q, error_d;
  logic              kill_q, kill_d;
  logic              run, cmd_ok, wd_expire;

  assign run    = (state_q == S_RUN);
  assign cmd_ok = (cmd_passes != 4'd0) && (cmd_passes <= MAX_P);

  conv_decoder_watchdog #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (!run || dec_ready),
    .en_i    (run),
    .expire_o(wd_expire)
  );

  always_comb begin
    state_d  = state_q;
    passes_d = passes_q;
    pass_d   = pass_q;
    pix_d    = pix_q;
    clr_d    = clr_q;
    error_d  = error_q;
    kill_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_ok) begin
            passes_d = cmd_passes;
            pass_d   = '0;
            pix_d    = '0;
            clr_d    = '0;
            error_d  = 1'b0;
            state_d  = S_CLEAR;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        pix_d = '0;
        if (clr_q == CLR_LAST) begin
          state_d = S_RUN;
        end else begin
          clr_d = clr_q + CLR_W'(1);
        end
      end
      S_RUN: begin
        if (dec_ready) begin
          pix_d = pix_q + PIX_AW'(1);
          if (pix_q == PIX_LAST) begin
            state_d = S_NEXT;
          end
        end
        if (wd_expire) begin
          error_d = 1'b1;
          kill_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_NEXT: begin
        if ({1'b0, pass_q} == passes_q - 4'd1) begin
          state_d = S_DONE;
        end else begin
          pass_d  = pass_q + 3'd1;
          clr_d   = '0;
          state_d = S_CLEAR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort outranks everything, including a coincident final pixel; its write still goes out combinationally.
    if (abort && (state_q == S_CLEAR || state_q == S_RUN || state_q == S_NEXT)) begin
      state_d = S_IDLE;
      kill_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      passes_q <= '0;
      pass_q   <= '0;
      pix_q    <= '0;
      clr_q    <= '0;
      error_q  <= 1'b0;
      kill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      passes_q <= passes_d;
      pass_q   <= pass_d;
      pix_q    <= pix_d;
      clr_q    <= clr_d;
      error_q  <= error_d;
      kill_q   <= kill_d;
    end
  end

  // The datapath stays in reset while rst is low, during CLEAR, and for one cycle after an abort or timeout.
  assign dec_rst    = !rst || (state_q == S_CLEAR) || kill_q;
  assign dec_start  = run;
  assign wr_en      = run && dec_ready;
  assign wr_addr    = ({{(BUF_AW-3){1'b0}}, pass_q} * PASS_STRIDE) + {{(BUF_AW-PIX_AW){1'b0}}, pix_q};
  assign pass_idx   = pass_q;
  assign cmd_ready  = rst && (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign layer_done = (state_q == S_DONE);
  assign error      = error_q;

endmodule
